// File: rtl/ram4096_16bit.sv
// ram4096_16bit: 4096 x 16 synchronous single-port RAM built from 16 banks of
// 256 words. Write has priority over read; the output register is the only
// state cleared by reset, the array itself keeps its contents across rst.

// One 256 x 16 bank: synchronous write, combinational read of the addressed word.
module ram4096_16bit_bank (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [7:0]  i_addr,
    input  logic [15:0] i_din,
    output logic [15:0] o_dout
);
    logic [15:0] r_mem [0:255];

    // Store write data into the addressed word when this bank is selected
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_din;
    end

    assign o_dout = r_mem[i_addr];
endmodule

module ram4096_16bit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_in,
    input  logic [11:0] i_add,
    input  logic        i_read,
    input  logic        i_write,
    input  logic        i_en1,
    output logic [15:0] o_out
);
    localparam int NUM_BANKS = 16;

    logic [NUM_BANKS-1:0] w_bank_sel;
    logic [NUM_BANKS-1:0] w_bank_we;
    logic [15:0]          w_bank_dout [NUM_BANKS];
    logic [15:0]          w_rd_data;
    logic                 w_rd_en;
    logic [15:0]          r_out;

    // One-hot bank decode gated by chip enable; only the selected bank may write
    always_comb begin
        w_bank_sel = '0;
        if (i_en1) w_bank_sel[i_add[11:8]] = 1'b1;
        w_bank_we  = w_bank_sel & {NUM_BANKS{i_write}};
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            ram4096_16bit_bank u_bank (
                .i_clk  (i_clk),
                .i_we   (w_bank_we[g]),
                .i_addr (i_add[7:0]),
                .i_din  (i_in),
                .o_dout (w_bank_dout[g])
            );
        end
    endgenerate

    // Read mux picks the word from the addressed bank
    assign w_rd_data = w_bank_dout[i_add[11:8]];

    // A read only happens when enabled and not writing; writes never update out
    assign w_rd_en = i_en1 & i_read & ~i_write;

    // Registered read data; reset clears it immediately and blocks reads
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_out <= 16'h0000;
        else if (w_rd_en) r_out <= w_rd_data;
    end

    assign o_out = r_out;
endmodule

// File: tb/tb_ram4096_16bit.sv
// Self-checking bench for ram4096_16bit: directed cases from the test plan
// followed by randomized traffic against an array-based reference model.
module tb_ram4096_16bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic [11:0] add = '0;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic        en1 = 1'b0;
    logic [15:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: plain word array plus the expected output register
    logic [15:0] ref_mem [4096];
    logic [15:0] ref_out;
    int          pool[$];

    ram4096_16bit dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_in    (din),
        .i_add   (add),
        .i_read  (rd),
        .i_write (wr),
        .i_en1   (en1),
        .o_out   (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive on negedge, update model at posedge, check just after
    task automatic cyc(input string tag, input logic e, input logic r, input logic w,
                       input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        en1 = e; rd = r; wr = w; add = a; din = d;
        @(posedge clk);
        if (rst)                ref_out = 16'h0000;
        else if (e && r && !w)  ref_out = ref_mem[a];
        if (e && w)             ref_mem[a] = d;
        #1;
        chk(tag, dout, ref_out);
    endtask

    initial begin
        ref_out = 16'h0000;
        // reset state
        #2;
        chk("reset_out", dout, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-cycle after a read loads 1234, memory must survive
        cyc("rst_wr",   1, 0, 1, 12'd40, 16'h1234);
        cyc("rst_rd",   1, 1, 0, 12'd40, 16'h0000);
        chk("rst_loaded", dout, 16'h1234);
        #2 rst = 1'b1;
        #1 ref_out = 16'h0000;
        chk("rst_async", dout, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc("rst_reread", 1, 1, 0, 12'd40, 16'h0000);
        chk("rst_mem_kept", dout, 16'h1234);

        // writes honoured and reads blocked while rst held
        rst = 1'b1;
        cyc("rsth_wr", 1, 0, 1, 12'd300, 16'h4321);
        cyc("rsth_rd", 1, 1, 0, 12'd300, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc("rsth_after", 1, 1, 0, 12'd300, 16'h0000);
        chk("rsth_data", dout, 16'h4321);

        // bank sweep: write with read also high, out must hold
        for (int k = 0; k < 8; k++)
            cyc("sweep_wr", 1, 1, 1, 12'(2 + 512*k), 16'(2 + 512*k));
        for (int k = 0; k < 8; k++) begin
            cyc("sweep_rd", 1, 1, 0, 12'(2 + 512*k), 16'h0);
            chk("sweep_val", dout, 16'(2 + 512*k));
        end

        // boundaries and bank edge
        cyc("bnd_wr", 1, 0, 1, 12'd4095, 16'hFFFF);
        cyc("bnd_wr", 1, 0, 1, 12'd0,    16'hA5A5);
        cyc("bnd_wr", 1, 0, 1, 12'd255,  16'h0255);
        cyc("bnd_wr", 1, 0, 1, 12'd256,  16'h0256);
        cyc("bnd_rd", 1, 1, 0, 12'd4095, 16'h0); chk("bnd_4095", dout, 16'hFFFF);
        cyc("bnd_rd", 1, 1, 0, 12'd0,    16'h0); chk("bnd_0",    dout, 16'hA5A5);
        cyc("bnd_rd", 1, 1, 0, 12'd255,  16'h0); chk("bnd_255",  dout, 16'h0255);
        cyc("bnd_rd", 1, 1, 0, 12'd256,  16'h0); chk("bnd_256",  dout, 16'h0256);

        // enable gating
        cyc("en_wr",   1, 0, 1, 12'd100, 16'h00FF);
        cyc("en_off",  0, 0, 1, 12'd100, 16'hBEEF);
        cyc("en_rdoff",0, 1, 0, 12'd100, 16'h0);
        chk("en_hold", dout, 16'h0256);
        cyc("en_rd",   1, 1, 0, 12'd100, 16'h0);
        chk("en_kept", dout, 16'h00FF);

        // idle strobes with moving address/data
        for (int k = 0; k < 6; k++)
            cyc("idle", 1, 0, 0, 12'($urandom), 16'($urandom));
        cyc("idle_rd", 1, 1, 0, 12'd4095, 16'h0);
        chk("idle_mem", dout, 16'hFFFF);

        // back-to-back write then read
        cyc("b2b_wr", 1, 0, 1, 12'd7, 16'h0001);
        cyc("b2b_rd", 1, 1, 0, 12'd7, 16'h0);
        chk("b2b_val", dout, 16'h0001);

        // random traffic on a pool of pre-written addresses
        for (int k = 0; k < 64; k++) begin
            int a;
            a = int'($urandom_range(0, 4095));
            pool.push_back(a);
            cyc("rnd_init", 1, 0, 1, 12'(a), 16'($urandom));
        end
        for (int k = 0; k < 2000; k++) begin
            int a;
            a = pool[$urandom_range(0, pool.size() - 1)];
            cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                12'(a), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
